// File: rtl/cd_clock_gen_pkg.sv
// Shared constants for the clock-divider core: default divide ratios and channel count.
package cd_pack;
    localparam int CD_NUM_CH   = 4;
    localparam int CD_DIV_VGA  = 4;
    localparam int CD_DIV_UART = 54;
    localparam int CD_DIV_LM   = 100000;
    localparam int CD_DIV_DB   = 1000000;
endpackage

// File: rtl/cd_channel.sv
// One divided-clock channel: wrap counter plus registered 50% clock and rising-edge tick.
module cd_channel #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync,
    output logic clk_out,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HALF = W'(DIV / 2);

    // Odd or tiny ratios cannot give a 50% duty square wave.
    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $fatal(1, "cd_channel: DIV=%0d must be even and >= 2", DIV);
    end

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!en || sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tick <= (cnt == '0);
            if (cnt == '0)
                clk_out <= 1'b1;
            else if (cnt == HALF)
                clk_out <= 1'b0;
        end
    end
endmodule

// File: rtl/cd_clock_gen.sv
// Four independent even-ratio clock dividers sharing enable and phase-restart controls.
module cd_clock_gen
    import cd_pack::*;
#(
    parameter int DIV_VGA  = CD_DIV_VGA,
    parameter int DIV_UART = CD_DIV_UART,
    parameter int DIV_LM   = CD_DIV_LM,
    parameter int DIV_DB   = CD_DIV_DB
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync,
    output logic clk_VGA,
    output logic clk_UART,
    output logic clk_LM,
    output logic clk_DB,
    output logic tick_VGA,
    output logic tick_UART,
    output logic tick_LM,
    output logic tick_DB,
    output logic running
);
    localparam int DIVS [CD_NUM_CH] = '{DIV_VGA, DIV_UART, DIV_LM, DIV_DB};

    logic [CD_NUM_CH-1:0] clks;
    logic [CD_NUM_CH-1:0] ticks;

    for (genvar i = 0; i < CD_NUM_CH; i++) begin : g_ch
        cd_channel #(.DIV(DIVS[i])) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .sync    (sync),
            .clk_out (clks[i]),
            .tick    (ticks[i])
        );
    end

    assign {clk_DB, clk_LM, clk_UART, clk_VGA}     = clks;
    assign {tick_DB, tick_LM, tick_UART, tick_VGA} = ticks;

    // A restart edge still counts as running; only en low idles the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            running <= 1'b0;
        else
            running <= en;
    end
endmodule

// File: tb/tb_cd_clock_gen.sv
// Bench for cd_clock_gen: phase-count reference model checked every cycle plus literal pins.
module tb_cd_clock_gen;
    localparam int D_VGA = 4, D_UART = 6, D_LM = 10, D_DB = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic sync = 1'b0;
    logic clk_VGA, clk_UART, clk_LM, clk_DB;
    logic tick_VGA, tick_UART, tick_LM, tick_DB;
    logic running;

    cd_clock_gen #(.DIV_VGA(D_VGA), .DIV_UART(D_UART), .DIV_LM(D_LM), .DIV_DB(D_DB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .clk_VGA(clk_VGA), .clk_UART(clk_UART), .clk_LM(clk_LM), .clk_DB(clk_DB),
        .tick_VGA(tick_VGA), .tick_UART(tick_UART), .tick_LM(tick_LM), .tick_DB(tick_DB),
        .running(running)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            passes++;
    endtask

    wire [3:0] clks  = {clk_DB, clk_LM, clk_UART, clk_VGA};
    wire [3:0] ticks = {tick_DB, tick_LM, tick_UART, tick_VGA};

    // Model: n = number of counting edges since the last idle/restart/reset (-1 = idle).
    // After counting edge n a channel is high for the first DIV/2 edges of each period.
    int n = -1;
    bit mrun = 1'b0;
    int divs [4] = '{D_VGA, D_UART, D_LM, D_DB};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= -1;
            mrun <= 1'b0;
        end else if (!en || sync) begin
            n <= -1;
            mrun <= en;
        end else begin
            n <= n + 1;
            mrun <= 1'b1;
        end
    end

    function automatic logic [3:0] exp_clks(input int k);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i] = (k >= 0) && ((k % divs[i]) < divs[i] / 2);
        return r;
    endfunction

    function automatic logic [3:0] exp_ticks(input int k);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[i] = (k >= 0) && ((k % divs[i]) == 0);
        return r;
    endfunction

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_clks", 32'(clks), 32'(exp_clks(n)));
            chk("model_ticks", 32'(ticks), 32'(exp_ticks(n)));
            chk("model_running", 32'(running), 32'(mrun));
        end
    end

    int hi_cnt [4];
    int tk_cnt [4];

    initial begin
        cmp_on = 1'b1;
        // Reset held with en high: everything stays 0.
        repeat (3) begin
            @(negedge clk);
            chk("reset_clks", 32'(clks), 32'h0);
            chk("reset_run", 32'(running), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin hi_cnt[i] = 0; tk_cnt[i] = 0; end
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            if (e == 0) begin
                chk("first_edge_clks", 32'(clks), 32'hF);
                chk("first_edge_ticks", 32'(ticks), 32'hF);
                chk("first_edge_run", 32'(running), 32'h1);
            end
            for (int i = 0; i < 4; i++) begin
                hi_cnt[i] += int'(clks[i]);
                tk_cnt[i] += int'(ticks[i]);
            end
        end
        // 60 edges span whole periods of 4, 6, 10 and 20.
        chk("hi_vga", hi_cnt[0], 30);
        chk("hi_uart", hi_cnt[1], 30);
        chk("hi_lm", hi_cnt[2], 30);
        chk("hi_db", hi_cnt[3], 30);
        chk("tk_vga", tk_cnt[0], 15);
        chk("tk_uart", tk_cnt[1], 10);
        chk("tk_lm", tk_cnt[2], 6);
        chk("tk_db", tk_cnt[3], 3);

        // Alignment restart.
        repeat (140) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        chk("sync_edge_clks", 32'(clks), 32'h0);
        chk("sync_edge_run", 32'(running), 32'h1);
        sync = 1'b0;
        @(negedge clk);
        chk("post_sync_clks", 32'(clks), 32'hF);
        chk("post_sync_ticks", 32'(ticks), 32'hF);

        // Enable drop while clk_DB is high at cnt=4.
        repeat (4) @(negedge clk);
        chk("db_high_before_drop", 32'(clk_DB), 32'h1);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("en_low_clks", 32'(clks), 32'h0);
            chk("en_low_ticks", 32'(ticks), 32'h0);
            chk("en_low_run", 32'(running), 32'h0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("reenable_clks", 32'(clks), 32'hF);

        // en low wins over sync.
        en = 1'b0;
        sync = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("prio_clks", 32'(clks), 32'h0);
            chk("prio_run", 32'(running), 32'h0);
        end
        en = 1'b1;
        sync = 1'b0;

        // Async reset mid-period drops outputs without a clock edge.
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clks", 32'(clks), 32'h0);
        chk("async_rst_ticks", 32'(ticks), 32'h0);
        chk("async_rst_run", 32'(running), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_clks", 32'(clks), 32'hF);

        // Randomized enable, restart and occasional reset pulses.
        repeat (3000) begin
            @(negedge clk);
            en   = ($urandom_range(0, 19) != 0);
            sync = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
